// File: rtl/direct_mapped_icache_if.sv
// ---------------------------------------------------------------------------
// direct_mapped_icache_if
// Bundles the fetch-side request/response handshake, the line-load bus
// command/return signals, the snoop invalidate and the perf counters of
// direct_mapped_icache.
//   slave  : cache side (drives req_ready, resp_*, command_*, data_in, counters)
//   master : fetch + bus side (drives req_*, resp_ready, bus_valid, data_out,
//            invalidate*)
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where both valid and ready are 1; once raised, valid and its payload
// hold steady until that edge.
// ---------------------------------------------------------------------------
interface direct_mapped_icache_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int CHUNKS_LOG = 4
);
  localparam int LINE_W = DATA_WIDTH * (2 ** CHUNKS_LOG);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  command_valid;
  logic                  command_store;
  logic                  command_rready;
  logic [ADDR_WIDTH-1:0] command_addr;
  logic [LINE_W-1:0]     data_in;
  logic                  bus_valid;
  logic [LINE_W-1:0]     data_out;
  logic                  invalidate;
  logic [ADDR_WIDTH-1:0] invalidate_addr;
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;

  modport slave (
    input  req_valid, req_addr, resp_ready, bus_valid, data_out,
           invalidate, invalidate_addr,
    output req_ready, resp_valid, resp_data, command_valid, command_store,
           command_rready, command_addr, data_in, hit_count, miss_count
  );

  modport master (
    output req_valid, req_addr, resp_ready, bus_valid, data_out,
           invalidate, invalidate_addr,
    input  req_ready, resp_valid, resp_data, command_valid, command_store,
           command_rready, command_addr, data_in, hit_count, miss_count
  );
endinterface

// File: rtl/direct_mapped_icache.sv
// ---------------------------------------------------------------------------
// direct_mapped_icache
// Read-only direct-mapped instruction cache between fetch and one port of the
// cache memory bus. Hits return one word; misses load a whole line over the
// bus and install it. Snoop invalidates clear matching lines.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : direct_mapped_icache_if.slave (fetch req/resp, bus command
//                and line return, snoop invalidate, perf counters)
//   state_o    : current FSM state (0 IDLE, 1 LOOKUP, 2 MISS, 3 RESP)
// Optional feature macro: ICACHE_PERF_CNT_EN enables the hit/miss counters;
// without it both counters read 0 and no counter flops exist.
// ---------------------------------------------------------------------------
module direct_mapped_icache #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int CHUNKS_LOG = 4,
  parameter int SETS_LOG   = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  direct_mapped_icache_if.slave  bus,
  output logic [1:0]             state_o
);
  localparam int WB     = $clog2(DATA_WIDTH / 8);
  localparam int OFF    = CHUNKS_LOG + WB;
  localparam int TAG_W  = ADDR_WIDTH - OFF - SETS_LOG;
  localparam int SETS   = 2 ** SETS_LOG;
  localparam int LINE_W = DATA_WIDTH * (2 ** CHUNKS_LOG);
  localparam int DW_LOG = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_MISS   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic                  poison_q, poison_d;
  logic [SETS-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [SETS];
  logic [LINE_W-1:0]     line_q [SETS];

  logic [SETS_LOG-1:0]   idx, inv_idx;
  logic [CHUNKS_LOG-1:0] word;
  logic [TAG_W-1:0]      tag, inv_tag;
  logic [CHUNKS_LOG+DW_LOG-1:0] word_bit;
  logic                  inv_match, inv_same_line, hit, fill;
  logic [DATA_WIDTH-1:0] array_word, fill_word;
  logic                  req_ready_c;
  logic                  lookup_hit, lookup_miss;
  logic                  unused_bits;

  assign idx      = addr_q[OFF +: SETS_LOG];
  assign word     = addr_q[OFF-1 -: CHUNKS_LOG];
  assign tag      = addr_q[ADDR_WIDTH-1 : OFF+SETS_LOG];
  assign inv_idx  = bus.invalidate_addr[OFF +: SETS_LOG];
  assign inv_tag  = bus.invalidate_addr[ADDR_WIDTH-1 : OFF+SETS_LOG];
  assign word_bit = {word, {DW_LOG{1'b0}}};

  assign array_word = line_q[idx][word_bit +: DATA_WIDTH];
  assign fill_word  = bus.data_out[word_bit +: DATA_WIDTH];

  // Snoop hits a currently valid line.
  assign inv_match     = bus.invalidate && valid_q[inv_idx] && (tag_q[inv_idx] == inv_tag);
  // Snoop names the line of the latched request, valid or not (poison source).
  assign inv_same_line = bus.invalidate && (inv_idx == idx) && (inv_tag == tag);
  // A same-cycle snoop of the looked-up line turns a hit into a miss.
  assign hit  = valid_q[idx] && (tag_q[idx] == tag) && !(inv_match && (inv_idx == idx));
  assign fill = (state_q == S_MISS) && bus.bus_valid;

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    resp_d             = resp_q;
    req_ready_c        = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = resp_q;
    bus.command_valid  = 1'b0;
    bus.command_rready = 1'b0;
    bus.command_addr   = '0;
    lookup_hit         = 1'b0;
    lookup_miss        = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          lookup_hit     = 1'b1;
          bus.resp_valid = 1'b1;
          bus.resp_data  = array_word;
          // Hold the word in case fetch stalls.
          resp_d         = array_word;
          state_d        = bus.resp_ready ? S_IDLE : S_RESP;
        end else begin
          lookup_miss = 1'b1;
          state_d     = S_MISS;
        end
      end
      S_MISS: begin
        bus.command_valid  = 1'b1;
        bus.command_rready = 1'b1;
        bus.command_addr   = {addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
        if (bus.bus_valid) begin
          resp_d  = fill_word;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    poison_d = poison_q;
    if ((state_q == S_MISS) && inv_same_line) poison_d = 1'b1;
    if (state_d != S_MISS) poison_d = 1'b0;

    // Fill first, then the snoop, so a coinciding invalidate wins.
    valid_d = valid_q;
    if (fill) valid_d[idx] = !(poison_q || inv_same_line);
    if (inv_match) valid_d[inv_idx] = 1'b0;
  end

  assign bus.req_ready     = req_ready_c && !reset;
  assign bus.command_store = 1'b0;
  assign bus.data_in       = '0;
  assign state_o           = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      resp_q   <= '0;
      poison_q <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      resp_q   <= resp_d;
      poison_q <= poison_d;
      valid_q  <= valid_d;
    end
  end

  // Tag/data arrays are not reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill && !reset) begin
      tag_q[idx]  <= tag;
      line_q[idx] <= bus.data_out;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (lookup_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (lookup_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
  assign unused_bits    = ^{addr_q[WB-1:0], bus.invalidate_addr[OFF-1:0]};
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
  assign unused_bits    = ^{addr_q[WB-1:0], bus.invalidate_addr[OFF-1:0],
                            lookup_hit, lookup_miss};
`endif
endmodule

// File: tb/tb_direct_mapped_icache.sv
// ---------------------------------------------------------------------------
// tb_direct_mapped_icache
// Bench for direct_mapped_icache: a line-return bus responder (word i of a
// line = line address + i), request driver tasks, an expected-data queue and
// scenario tasks covering cold miss, hit, conflict, snoop, poison,
// backpressure, reset mid-miss and the optional perf counters.
// ---------------------------------------------------------------------------
module tb_direct_mapped_icache;
  localparam int DW     = 64;
  localparam int AW     = 64;
  localparam int LINE_W = DW * 16;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  direct_mapped_icache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHUNKS_LOG(4)) bus_if ();

  direct_mapped_icache #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHUNKS_LOG(4), .SETS_LOG(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .state_o (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  int exp_hits = 0;
  int exp_misses = 0;

  // Bus responder state
  int cmd_count = 0;
  int cmd_reissue = 0;
  int bus_lat = 20;
  logic [AW-1:0] last_cmd_addr = '0;

  initial begin
    int cnt;
    bit busy;
    busy = 0;
    cnt = 0;
    bus_if.bus_valid = 1'b0;
    bus_if.data_out  = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        bus_if.bus_valid = 1'b0;
        busy = 0;
      end else if (bus_if.bus_valid) begin
        bus_if.bus_valid = 1'b0;
        busy = 0;
        if (bus_if.command_valid) cmd_reissue++;
      end else if (!busy && bus_if.command_valid) begin
        busy = 1;
        cnt = bus_lat;
        last_cmd_addr = bus_if.command_addr;
        cmd_count++;
      end else if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          for (int i = 0; i < 16; i++)
            bus_if.data_out[i*DW +: DW] = last_cmd_addr + 64'(i);
          bus_if.bus_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  // One request: push expected word, drive, wait for response, check.
  task automatic do_req(input logic [AW-1:0] addr, input bit exp_hit, input int stall,
                        input bit inv_en, input logic [AW-1:0] inv_addr, input string name);
    int lat;
    int c0;
    logic [DW-1:0] exp;
    logic [DW-1:0] held;
    lat = 0;
    while (!bus_if.req_ready && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (bus_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready: got %b want 1", name, bus_if.req_ready);
      return;
    end
    exp_q.push_back((addr & ~64'h7F) + ((addr >> 3) & 64'hF));
    if (exp_hit) exp_hits++; else exp_misses++;
    c0 = cmd_count;
    bus_if.resp_ready = (stall == 0);
    bus_if.req_valid  = 1'b1;
    bus_if.req_addr   = addr;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    lat = 1;
    while (!bus_if.resp_valid && lat < 200) begin
      bus_if.invalidate      = inv_en && (lat == 3);
      bus_if.invalidate_addr = inv_addr;
      @(posedge clk); #1; lat++;
    end
    bus_if.invalidate = 1'b0;
    checks++;
    if (bus_if.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_valid timeout: got %b want 1", name, bus_if.resp_valid);
      void'(exp_q.pop_front());
      bus_if.resp_ready = 1'b1;
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if (bus_if.resp_data !== exp) begin
      errors++;
      $display("FAIL %s resp_data: got %h want %h", name, bus_if.resp_data, exp);
    end
    checks++;
    if ((cmd_count - c0) != (exp_hit ? 0 : 1)) begin
      errors++;
      $display("FAIL %s bus commands: got %0d want %0d", name, cmd_count - c0, exp_hit ? 0 : 1);
    end
    if (exp_hit) begin
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL %s hit latency: got %0d want 1", name, lat);
      end
    end
    if (stall > 0) begin
      held = bus_if.resp_data;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        checks++;
        if (bus_if.resp_valid !== 1'b1 || bus_if.resp_data !== held) begin
          errors++;
          $display("FAIL %s stall hold: got v=%b d=%h want v=1 d=%h", name,
                   bus_if.resp_valid, bus_if.resp_data, held);
        end
      end
      bus_if.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (bus_if.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s resp drop: got %b want 0", name, bus_if.resp_valid);
    end
  endtask

  task automatic pulse_inv(input logic [AW-1:0] addr);
    bus_if.invalidate      = 1'b1;
    bus_if.invalidate_addr = addr;
    @(posedge clk); #1;
    bus_if.invalidate = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_if.req_ready !== 1'b0 || bus_if.resp_valid !== 1'b0 || bus_if.command_valid !== 1'b0 ||
        bus_if.command_rready !== 1'b0 || bus_if.command_addr !== '0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset outputs: got rdy=%b rv=%b cv=%b crr=%b ca=%h st=%0d want 0,0,0,0,0,0",
               bus_if.req_ready, bus_if.resp_valid, bus_if.command_valid,
               bus_if.command_rready, bus_if.command_addr, dbg_state);
    end
    checks++;
    if (bus_if.hit_count !== 32'd0 || bus_if.miss_count !== 32'd0 ||
        bus_if.command_store !== 1'b0 || bus_if.data_in !== '0) begin
      errors++;
      $display("FAIL reset counters/consts: got hit=%0d miss=%0d store=%b want 0,0,0",
               bus_if.hit_count, bus_if.miss_count, bus_if.command_store);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset release req_ready: got %b want 1", bus_if.req_ready);
    end
  endtask

  task automatic test_cold_miss();
    int r0;
    r0 = cmd_reissue;
    bus_lat = 20;
    do_req(64'h1008, 1'b0, 0, 1'b0, '0, "t1_cold");
    checks++;
    if (last_cmd_addr !== 64'h1000) begin
      errors++;
      $display("FAIL t1_cmd_addr: got %h want %h", last_cmd_addr, 64'h1000);
    end
    checks++;
    if (cmd_reissue != r0) begin
      errors++;
      $display("FAIL t1_cmd_after_fill: got %0d reissues want 0", cmd_reissue - r0);
    end
  endtask

  task automatic test_hit();
    do_req(64'h1078, 1'b1, 0, 1'b0, '0, "t2_hit");
  endtask

  task automatic test_conflict();
    bus_lat = $urandom_range(2, 12);
    do_req(64'h3008, 1'b0, 0, 1'b0, '0, "t3_conflict");
    checks++;
    if (last_cmd_addr !== 64'h3000) begin
      errors++;
      $display("FAIL t3_cmd_addr: got %h want %h", last_cmd_addr, 64'h3000);
    end
    do_req(64'h1008, 1'b0, 0, 1'b0, '0, "t3_refill");
  endtask

  task automatic test_snoop();
    bus_lat = $urandom_range(2, 12);
    pulse_inv(64'h1040);
    do_req(64'h1000, 1'b0, 0, 1'b0, '0, "t4_snooped");
    pulse_inv(64'h5000);
    do_req(64'h1000, 1'b1, 0, 1'b0, '0, "t4_tag_mismatch");
  endtask

  task automatic test_poison();
    bus_lat = 20;
    do_req(64'h2010, 1'b0, 0, 1'b1, 64'h2000, "t5_poisoned");
    do_req(64'h2010, 1'b0, 0, 1'b0, '0, "t5_refetch");
    do_req(64'h2010, 1'b1, 0, 1'b0, '0, "t5_now_hit");
  endtask

  task automatic test_counters(input string name);
`ifdef ICACHE_PERF_CNT_EN
    checks++;
    if (bus_if.hit_count !== 32'(exp_hits) || bus_if.miss_count !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL %s counters: got hit=%0d miss=%0d want hit=%0d miss=%0d", name,
               bus_if.hit_count, bus_if.miss_count, exp_hits, exp_misses);
    end
`else
    checks++;
    if (bus_if.hit_count !== 32'd0 || bus_if.miss_count !== 32'd0) begin
      errors++;
      $display("FAIL %s counters: got hit=%0d miss=%0d want 0,0", name,
               bus_if.hit_count, bus_if.miss_count);
    end
`endif
  endtask

  task automatic test_backpressure();
    bus_lat = $urandom_range(2, 12);
    do_req(64'h2018, 1'b1, 5, 1'b0, '0, "t6_stall_hit");
    do_req(64'h4020, 1'b0, 5, 1'b0, '0, "t6_stall_miss");
    test_counters("t6_tally");
  endtask

  task automatic test_reset_mid_miss();
    int w;
    bus_lat = 20;
    bus_if.resp_ready = 1'b1;
    bus_if.req_valid  = 1'b1;
    bus_if.req_addr   = 64'h6000;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    w = 0;
    while (!bus_if.command_valid && w < 10) begin
      @(posedge clk); #1; w++;
    end
    checks++;
    if (bus_if.command_valid !== 1'b1) begin
      errors++;
      $display("FAIL t6_miss_start: got command_valid=%b want 1", bus_if.command_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus_if.command_valid !== 1'b0 || dbg_state !== 2'd0 || bus_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL t6_in_reset: got cv=%b st=%0d rdy=%b want 0,0,0",
               bus_if.command_valid, dbg_state, bus_if.req_ready);
    end
    checks++;
    if (bus_if.hit_count !== 32'd0 || bus_if.miss_count !== 32'd0) begin
      errors++;
      $display("FAIL t6_counters_reset: got hit=%0d miss=%0d want 0,0",
               bus_if.hit_count, bus_if.miss_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.command_valid !== 1'b0 || bus_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL t6_after_reset: got cv=%b rdy=%b want 0,1",
               bus_if.command_valid, bus_if.req_ready);
    end
    bus_lat = $urandom_range(2, 12);
    do_req(64'h1000, 1'b0, 0, 1'b0, '0, "t6_post_reset_set32");
    do_req(64'h4020, 1'b0, 0, 1'b0, '0, "t6_post_reset_set0");
    do_req(64'h1000, 1'b1, 0, 1'b0, '0, "t6_post_reset_hit");
    test_counters("t6_post_reset_tally");
  endtask

  initial begin
    reset                  = 1'b1;
    bus_if.req_valid       = 1'b0;
    bus_if.req_addr        = '0;
    bus_if.resp_ready      = 1'b1;
    bus_if.invalidate      = 1'b0;
    bus_if.invalidate_addr = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_snoop();
    test_poison();
    test_backpressure();
    test_reset_mid_miss();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
